systolic_data_setup: RTL and testbench
======================================

SYSTOLIC_DATA_SETUP -- requirements
Module: systolic_data_setup

Interface
REQ-001 Parameter LANES, default 16, number of 8-bit lanes per unified-buffer row.
REQ-002 Parameter ADDR_W, default 8, unified-buffer address width (256 rows).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  one-cycle request to stream a block of rows.
REQ-006 Port base_addr  input  ADDR_W  first row address; sampled with start.
REQ-007 Port row_count  input  ADDR_W+1  rows to stream; sampled with start.
REQ-008 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port ub_enb  output  1  read enable to unified buffer port B.
REQ-011 Port ub_addrb  output  ADDR_W  read address to unified buffer port B.
REQ-012 Port ub_doutb  input  LANES*8  buffer read data, valid the cycle after ub_enb; held while ub_enb is low.
REQ-013 Port array_data  output  LANES*8  skewed row data; lane i occupies bits 8i+7:8i.
REQ-014 Port array_valid  output  LANES  per-lane valid for array_data.
REQ-015 Port stall  input  1  downstream hold; present only with SDS_STALL_EN.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-017 IDLE->READ on start with row_count != 0; start with row_count == 0 SHALL go to DONE, with no reads.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 row_count > 2**ADDR_W SHALL be clamped to 2**ADDR_W.
REQ-020 In READ, ub_enb SHALL be high one cycle per row, with ub_addrb = base_addr + k mod 2**ADDR_W for k = 0..row_count-1, so addresses wrap 255->0.
REQ-021 READ->DRAIN SHALL occur after the last row is issued; ub_enb SHALL be low outside READ.
REQ-022 A read-valid flag SHALL follow ub_enb with 1-cycle latency and mark ub_doutb as row data.
REQ-023 Lane i SHALL be delayed by exactly i register stages after ub_doutb, so lane 0 is combinational from ub_doutb.
REQ-024 For a row issued at cycle T, lane i SHALL present its byte with array_valid[i]=1 at cycle T+1+i.
REQ-025 When array_valid[i]=0, lane i data SHALL be zero.
REQ-026 DRAIN->DONE SHALL occur when no valid data remains in the skew stages; DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 For a first issue at T0 and R rows, done SHALL be high at T0+R+LANES (unstalled).
REQ-028 busy SHALL be high in READ, DRAIN and DONE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with busy=0, done=0, ub_enb=0, ub_addrb=0, array_valid=0, array_data=0, and all skew stages cleared.
REQ-030 Reset mid-operation SHALL abandon the block with no done pulse; the next start SHALL behave as from power-up.

Configuration
REQ-031 Macro SDS_STALL_EN: when defined, the stall port SHALL exist and stall=1 SHALL force ub_enb=0 and freeze the address counter, read-valid flag, skew stages, FSM and outputs.
REQ-032 With SDS_STALL_EN defined, all latencies SHALL extend by the number of stall cycles.
REQ-033 Without SDS_STALL_EN, the stall port SHALL be absent and the block SHALL never pause.

Structure
REQ-034 LANES, ADDR_W and the FSM state enumeration SHALL live in the shared package tpu_pkg.
REQ-035 One sub-module, sds_lane_delay (a parameterised depth-N byte+valid shift register), SHALL be instantiated per lane; depth 0 SHALL be a pass-through.

Verification
REQ-036 start, base_addr=0, row_count=1, row bytes 0x01..0x10 -> lane i shows 0x01+i at T0+1+i; done at T0+17.
REQ-037 base_addr=250, row_count=10 -> ub_addrb sequence 250..255,0..3; done at T0+26.
REQ-038 row_count=0 -> no ub_enb; done the cycle after start; busy high for one cycle.
REQ-039 start pulsed during DRAIN -> ignored; exactly one done; no extra reads.
REQ-040 rst_n asserted at cycle 5 of a 20-row block -> all outputs zero immediately; no done; a fresh 2-row block then completes at T0+18.
REQ-041 SDS_STALL_EN defined, 4 rows, stall high 3 cycles mid-READ -> ub_enb low, outputs held during stall; done at T0+23.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU sizing constants and data-setup FSM states
package tpu_pkg;

  localparam int LANES  = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } sds_state_e;

endpackage

// File: rtl/systolic_data_setup_if.sv
// rtl/systolic_data_setup_if.sv - control, unified-buffer and array bundle (stall under SDS_STALL_EN)
interface systolic_data_setup_if #(
  parameter int LANES  = tpu_pkg::LANES,
  parameter int ADDR_W = tpu_pkg::ADDR_W
);
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W:0]      row_count;
  logic                 busy;
  logic                 done;
  logic                 ub_enb;
  logic [ADDR_W-1:0]    ub_addrb;
  logic [LANES*8-1:0]   ub_doutb;
  logic [LANES*8-1:0]   array_data;
  logic [LANES-1:0]     array_valid;
`ifdef SDS_STALL_EN
  logic                 stall;

  modport master (
    input  start, base_addr, row_count, ub_doutb, stall,
    output busy, done, ub_enb, ub_addrb, array_data, array_valid
  );
  modport slave (
    output start, base_addr, row_count, ub_doutb, stall,
    input  busy, done, ub_enb, ub_addrb, array_data, array_valid
  );
`else
  modport master (
    input  start, base_addr, row_count, ub_doutb,
    output busy, done, ub_enb, ub_addrb, array_data, array_valid
  );
  modport slave (
    output start, base_addr, row_count, ub_doutb,
    input  busy, done, ub_enb, ub_addrb, array_data, array_valid
  );
`endif
endinterface

// File: rtl/sds_lane_delay.sv
// rtl/sds_lane_delay.sv - depth-N byte+valid shift register for one skewed lane
module sds_lane_delay #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       pending
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, en};
    assign data_out  = data_in;
    assign valid_out = valid_in;
    assign pending   = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0][7:0] data_q;
    logic [DEPTH-1:0]      valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
      end else if (en) begin
        data_q[0]  <= data_in;
        valid_q[0] <= valid_in;
        for (int j = 1; j < DEPTH; j++) begin
          data_q[j]  <= data_q[j-1];
          valid_q[j] <= valid_q[j-1];
        end
      end
    end

    // pending: a valid byte that has not yet reached the output stage
    always_comb begin
      pending = valid_in;
      for (int j = 0; j < DEPTH - 1; j++) pending = pending | valid_q[j];
    end

    assign data_out  = data_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_data_setup.sv
// rtl/systolic_data_setup.sv - streams unified-buffer rows into the array with per-lane skew
// Optional downstream hold port enabled by macro SDS_STALL_EN.
module systolic_data_setup
  import tpu_pkg::*;
#(
  parameter int LANES  = tpu_pkg::LANES,
  parameter int ADDR_W = tpu_pkg::ADDR_W
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_data_setup_if.master bus
);

  localparam logic [ADDR_W:0] ROW_MAX = {1'b1, {ADDR_W{1'b0}}};

  sds_state_e          state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     rows_clamped;
  logic                rd_valid;
  logic                adv;
  logic                accept;
  logic [LANES-1:0]    lane_pending;
  logic [LANES-1:0]    lane_valid;
  logic [LANES*8-1:0]  lane_data;

`ifdef SDS_STALL_EN
  assign adv = ~bus.stall;
`else
  assign adv = 1'b1;
`endif

  assign accept       = (state == IDLE) && bus.start;
  assign rows_clamped = (bus.row_count > ROW_MAX) ? ROW_MAX : bus.row_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (adv) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.row_count == '0) ? DONE : READ;
      READ:    if (remaining == (ADDR_W+1)'(1)) state_nxt = DRAIN;
      DRAIN:   if (lane_pending == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
    end else if (adv) begin
      rd_valid <= (state == READ);
      if (accept) begin
        addr      <= bus.base_addr;
        remaining <= rows_clamped;
      end else if (state == READ) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.ub_enb   = (state == READ) && adv;
  assign bus.ub_addrb = addr;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

  // lane i sits behind i register stages; lane 0 is straight from the buffer
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sds_lane_delay #(.DEPTH(i)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .data_in   (rd_valid ? bus.ub_doutb[8*i +: 8] : 8'h00),
      .valid_in  (rd_valid),
      .data_out  (lane_data[8*i +: 8]),
      .valid_out (lane_valid[i]),
      .pending   (lane_pending[i])
    );
  end

  assign bus.array_data  = lane_data;
  assign bus.array_valid = lane_valid;

endmodule

// File: tb/tb_systolic_data_setup.sv
// tb/tb_systolic_data_setup.sv - randomized self-checking bench for systolic_data_setup
module tb_systolic_data_setup;

  localparam int NL = tpu_pkg::LANES;
  localparam int DW = NL * 8;
`ifdef SDS_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [DW-1:0] mem [256];

  systolic_data_setup_if bus ();

  systolic_data_setup u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // unified buffer port B: one-cycle read latency, output held when not enabled
  always @(posedge clk) begin
    if (bus.ub_enb) bus.ub_doutb <= mem[bus.ub_addrb];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  DW'(bus.busy), '0);
    check({tag, "_done"},  DW'(bus.done), '0);
    check({tag, "_enb"},   DW'(bus.ub_enb), '0);
    check({tag, "_addr"},  DW'(bus.ub_addrb), '0);
    check({tag, "_valid"}, DW'(bus.array_valid), '0);
    check({tag, "_data"},  bus.array_data, '0);
  endtask

  // Model: e counts unstalled cycles since acceptance (e=1 is the first issue
  // cycle). Row k is issued at e=1+k, lane i shows it at e=2+k+i, done at R+NL+1.
  task automatic run_block(input int base, input int rc, input int stall_at,
                           input int stall_len, input int glitch_at, input int abort_at);
    int r, done_e, e, n, k;
    logic stl, exp_enb;
    logic [DW-1:0] exp_data, row;
    logic [NL-1:0] exp_valid;
    r      = (rc > 256) ? 256 : rc;
    done_e = (r == 0) ? 1 : r + NL + 1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 8'(base);
    bus.row_count = 9'(rc);
    #1 check("busy_before_accept", DW'(bus.busy), '0);
    @(negedge clk);
    e = 1;
    n = 1;
    while (e <= done_e + 1) begin
      stl = STALL_EN && (n >= stall_at) && (n < stall_at + stall_len);
`ifdef SDS_STALL_EN
      bus.stall = stl;
`endif
      if (n == glitch_at) begin
        bus.start     = 1'b1;
        bus.base_addr = 8'($urandom_range(0, 255));
        bus.row_count = 9'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1 check_all_zero("abort");
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("abort_no_done", DW'(bus.done), '0);
          check("abort_no_busy", DW'(bus.busy), '0);
        end
        rst_n = 1'b1;
`ifdef SDS_STALL_EN
        bus.stall = 1'b0;
`endif
        return;
      end
      #1;
      exp_enb   = !stl && (e >= 1) && (e <= r);
      exp_valid = '0;
      exp_data  = '0;
      for (int i = 0; i < NL; i++) begin
        k = e - 2 - i;
        if (k >= 0 && k < r) begin
          exp_valid[i]         = 1'b1;
          row                  = mem[(base + k) % 256];
          exp_data[8*i +: 8]   = row[8*i +: 8];
        end
      end
      check("ub_enb", DW'(bus.ub_enb), DW'(exp_enb));
      if (exp_enb) check("ub_addrb", DW'(bus.ub_addrb), DW'((base + e - 1) % 256));
      check("array_valid", DW'(bus.array_valid), DW'(exp_valid));
      check("array_data", bus.array_data, exp_data);
      check("done", DW'(bus.done), DW'(e == done_e));
      check("busy", DW'(bus.busy), DW'(e >= 1 && e <= done_e));
      if (!stl) e++;
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
`ifdef SDS_STALL_EN
    bus.stall = 1'b0;
`endif
  endtask

  initial begin
    logic [DW-1:0] seq_row;
    n_checks      = 0;
    n_pass        = 0;
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_count = '0;
    bus.ub_doutb  = '0;
`ifdef SDS_STALL_EN
    bus.stall     = 1'b0;
`endif
    for (int a = 0; a < 256; a++)
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NL; i++) seq_row[8*i +: 8] = 8'(i + 1);
    mem[0] = seq_row;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_block(0, 1, 0, 0, 0, 0);        // lane i shows 0x01+i, done at T0+17
    run_block(250, 10, 0, 0, 0, 0);     // address wrap 255 -> 0
    run_block(77, 0, 0, 0, 0, 0);       // empty block: DONE right after start
    run_block(40, 6, 0, 0, 9, 0);       // start during DRAIN ignored
    run_block(12, 20, 0, 0, 0, 5);      // reset at cycle 5 abandons the block
    run_block(200, 2, 0, 0, 0, 0);      // fresh block after reset
    run_block(100, 4, 3, 3, 0, 0);      // stall mid-READ when enabled

    for (int t = 0; t < 6; t++)
      run_block(int'($urandom_range(0, 255)), int'($urandom_range(1, 40)),
                int'($urandom_range(1, 12)), STALL_EN ? int'($urandom_range(0, 4)) : 0, 0, 0);

    run_block(int'($urandom_range(0, 255)), 300, 0, 0, 0, 0);
    run_block(int'($urandom_range(0, 255)), 511, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
